// File: rtl/proc_param_pkg.sv
// Shared constants for the parametrised multicycle core: opcodes, step
// encodings and the ALU operation select.
package proc_param_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SHL,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  function automatic logic is_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHL, OP_OR, OP_AND};
  endfunction

  function automatic alu_op_t alu_sel(input logic [3:0] op);
    alu_op_t sel;
    case (op)
      OP_SUB:  sel = ALU_SUB;
      OP_SHL:  sel = ALU_SHL;
      OP_OR:   sel = ALU_OR;
      OP_AND:  sel = ALU_AND;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/proc_param_if.sv
// Sequencer / memory side of the core, plus debug visibility of the step
// register and zero flag.
interface proc_param_if #(
  parameter int W = 16
);
  // Run is sampled only in T0; Done pulses for exactly one cycle in the final
  // step. During ld-T2 / st-T3 the core waits until MemReady=1 and completes in
  // that same cycle; MemReady at any other time has no effect.
  logic         Run;
  logic [W-1:0] DIN;
  logic         MemReady;
  logic         Done;
  logic [W-1:0] BusWires;
  logic [W-1:0] ADDR;
  logic [W-1:0] DOUT;
  logic         W_D;
  logic [1:0]   step;
  logic         z;

  modport master (
    output Run, DIN, MemReady,
    input  Done, BusWires, ADDR, DOUT, W_D, step, z
  );

  modport slave (
    input  Run, DIN, MemReady,
    output Done, BusWires, ADDR, DOUT, W_D, step, z
  );
endinterface

// File: rtl/proc_param_alu.sv
// Combinational ALU: add/sub/or/and and a zero-filling left shift by the low
// log2(W) bits of b. Arithmetic wraps modulo 2^W.
module proc_alu
  import proc_param_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_t      op,
  output logic [W-1:0] result,
  output logic         zero
);

  localparam int SB = $clog2(W);

  always_comb begin
    result = a + b;
    case (op)
      ALU_SUB: result = a - b;
      ALU_SHL: result = a << b[SB-1:0];
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/proc_param_regn.sv
// Enabled register with asynchronous active-low clear.
module regn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/proc_param.sv
// Multicycle core with W-bit datapath and NREG registers; a single shared bus
// moves data between registers, G, DIN and the memory address/data latches.
module proc_param
  import proc_param_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  proc_param_if.slave  bus
);

  localparam int RB  = $clog2(NREG);
  localparam int IRW = 4 + 2 * RB;

  logic [1:0]      step, step_nx;
  logic [IRW-1:0]  ir;
  logic [3:0]      opcode;
  logic [RB-1:0]   x, y;
  logic [NREG-1:0] xdec, ydec, rsel, r_en;
  logic [W-1:0]    r [NREG];
  logic [W-1:0]    a_q, g_q, alu_res, bus_val;
  logic            alu, alu_zero, z, gsel, is_mem;
  logic            rx_wr, a_en, g_en, addr_en, dout_en;

  assign opcode = ir[IRW-1 -: 4];
  assign x      = ir[2*RB-1 -: RB];
  assign y      = ir[RB-1:0];
  assign alu    = is_alu(opcode);
  assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);

  regn #(.W(IRW)) u_ir (
    .clk(Clock), .rst_n(Resetn), .en((step == T0) && bus.Run),
    .d(bus.DIN[W-1 -: IRW]), .q(ir)
  );

  always_comb begin
    step_nx = step;
    case (step)
      T0: if (bus.Run) step_nx = T1;
      T1: step_nx = (alu || is_mem) ? T2 : T0;
      T2: begin
        if (opcode == OP_LD) step_nx = bus.MemReady ? T0 : T2;
        else                 step_nx = T3;
      end
      T3: if ((opcode != OP_ST) || bus.MemReady) step_nx = T0;
      default: step_nx = T0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) step <= T0;
    else         step <= step_nx;
  end

  // Only T2 (ALU/ld/st) and T3 (ALU/st) are reachable, so the terms below are exclusive.
  assign bus.Done = ((step == T1) && !(alu || is_mem))
                 || ((step == T2) && (opcode == OP_LD) && bus.MemReady)
                 || ((step == T3) && (alu || bus.MemReady));
  assign bus.W_D  = (step == T3) && (opcode == OP_ST);

  always_comb begin
    rsel    = '0;
    gsel    = 1'b0;
    rx_wr   = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    addr_en = 1'b0;
    dout_en = 1'b0;
    case (step)
      T1: begin
        case (opcode)
          OP_MV:        begin rsel = ydec; rx_wr = 1'b1; end
          OP_MVI:       rx_wr = 1'b1;
          OP_MVNZ:      begin rsel = ydec; rx_wr = !z; end
          OP_LD, OP_ST: begin rsel = ydec; addr_en = 1'b1; end
          default:      if (alu) begin rsel = xdec; a_en = 1'b1; end
        endcase
      end
      T2: begin
        if (alu)                  begin rsel = ydec; g_en = 1'b1; end
        else if (opcode == OP_LD) rx_wr = bus.MemReady;
        else if (opcode == OP_ST) begin rsel = xdec; dout_en = 1'b1; end
      end
      T3: if (alu) begin gsel = 1'b1; rx_wr = 1'b1; end
      default: ;
    endcase
  end

  assign r_en = rx_wr ? xdec : '0;

  // DIN drives the bus whenever no register or G is selected.
  always_comb begin
    bus_val = '0;
    for (int i = 0; i < NREG; i++)
      if (rsel[i]) bus_val = bus_val | r[i];
    if (gsel) bus_val = bus_val | g_q;
    if (!(gsel || (|rsel))) bus_val = bus.DIN;
  end

  assign bus.BusWires = bus_val;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign xdec[i] = (x == RB'(i));
    assign ydec[i] = (y == RB'(i));
    regn #(.W(W)) u_r (
      .clk(Clock), .rst_n(Resetn), .en(r_en[i]), .d(bus_val), .q(r[i])
    );
  end

  regn #(.W(W)) u_a (.clk(Clock), .rst_n(Resetn), .en(a_en), .d(bus_val), .q(a_q));
  regn #(.W(W)) u_g (.clk(Clock), .rst_n(Resetn), .en(g_en), .d(alu_res), .q(g_q));
  regn #(.W(W)) u_addr (.clk(Clock), .rst_n(Resetn), .en(addr_en), .d(bus_val), .q(bus.ADDR));
  regn #(.W(W)) u_dout (.clk(Clock), .rst_n(Resetn), .en(dout_en), .d(bus_val), .q(bus.DOUT));

  proc_alu #(.W(W)) u_alu (
    .a(a_q), .b(bus_val), .op(alu_sel(opcode)), .result(alu_res), .zero(alu_zero)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)   z <= 1'b1;
    else if (g_en) z <= alu_zero;
  end

  assign bus.step = step;
  assign bus.z    = z;

endmodule

// File: doc/proc_param.md
Name: proc_param

Overview:
- Parametrised multicycle processor core, successor to the fixed 16-bit / 8-register core.
- Generalises data width and register count.
- Adds logical and shift operations, a zero flag, and a real memory port (address, data-out, write strobe) with a MemReady wait-state handshake.
- Sits between instruction/data source (DIN) and the memory/IO fabric, driven by an external Run/Done sequencer.

Parameters:
- W, 16: datapath width. Must satisfy W >= 4 + 2*log2(NREG).
- NREG, 8: number of general registers. Power of 2, 2..16.
- RB, $clog2(NREG): register index width. Derived, not overridable.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Run  in  1  start; sampled only in T0.
- DIN  in  W  instruction word, immediate, or load data.
- MemReady  in  1  memory acknowledge for ld/st.
- Done  out  1  one-cycle pulse in the final step of each instruction.
- BusWires  out  W  internal bus, observable.
- ADDR  out  W  registered memory address.
- DOUT  out  W  registered store data.
- W_D  out  1  write strobe.

Behaviour:
- Instruction format: opcode = DIN[W-1:W-4], X = next RB bits, Y = next RB bits; remaining low bits ignored.
- IR latches those 4+2*RB bits.
- Opcodes: 0 mv, 1 mvi, 2 add, 3 sub, 4 ld, 5 st, 6 mvnz, 7 shl, 8 or, 9 and. Opcodes 10-15 are NOP.
- Step FSM states T0..T3, 2-bit register.
- T0: if Run=1, IR<-DIN and go to T1; otherwise stay in T0 with IR held. Run is ignored in T1-T3.
- mv: T1: Rx<-Ry, Done.
- mvi: T1: Rx<-DIN (immediate presented on DIN during T1), Done.
- add/sub/or/and/shl, T1: A<-Rx.
- add/sub/or/and/shl, T2: G<-A op Ry; Z<-(result==0).
  - shl: A << Ry[$clog2(W)-1:0]; zero fill.
- add/sub/or/and/shl, T3: Rx<-G, Done.
- ld:
  - T1: ADDR<-Ry.
  - T2: hold in T2 while MemReady=0. On the cycle MemReady=1: Rx<-DIN, Done, go to T0.
- st:
  - T1: ADDR<-Ry.
  - T2: DOUT<-Rx.
  - T3: W_D=1 and hold in T3 until MemReady=1. On that cycle: Done, go to T0. W_D drops the next cycle.
- mvnz: T1: if Z=0 then Rx<-Ry; Done either way.
- NOP: T1: Done, no register write.
- Done and W_D are combinational from state/opcode. Done is exactly one cycle per instruction, then T0.
- Bus source is a one-hot select over {R0..R(NREG-1), G, DIN}. DIN is the default when nothing is selected. Only one source is enabled per step.
- Arithmetic is modulo 2^W; no carry or overflow flags.
- Mv with X=Y is legal and leaves the register unchanged.
- Reset (async, any state):
  - FSM -> T0.
  - R*, A, G, ADDR, DOUT, IR -> 0; Z -> 1.
  - Done=0, W_D=0 immediately.
  - An in-flight st is abandoned; no partial write is committed.
- MemReady asserted outside ld-T2 / st-T3 is ignored.
- MemReady already high on arrival in the wait state completes in that same cycle, with no extra cycle.
- Latency in cycles (T0 included): mv/mvi/mvnz/NOP 2; ALU ops 4; ld 3+waits; st 4+waits.

Decomposition:
- Package proc_param_pkg:
  - opcode constants (4-bit);
  - step encodings T0..T3;
  - ALU op select enum.
- Sub-module proc_alu: combinational, parameter W. Inputs A, B, op. Outputs result and zero.
- Existing regn is reused for R*, A, G and IR.
- X/Y decode is an NREG-wide one-hot generate.

Test Plan:
- Add: mvi R0,#5; mvi R1,#3; add R0,R1 -> R0=8, Z=0, Done on the 4th cycle after Run.
- Sub and mvnz: R0=8, R1=8: sub R0,R1 -> R0=0, Z=1; mvi R2,#7; mvnz R3,R2 -> R3 unchanged (0), Done after 2 cycles.
- Load with wait states: R1=0x0040; ld R4,R1 with MemReady low 3 cycles, then high with DIN=0xBEEF.
  - ADDR=0x0040 throughout.
  - Done coincides with MemReady.
  - R4=0xBEEF.
- Store: R5=0x1234, R6=0x0010; st R5,R6 -> ADDR=0x0010, DOUT=0x1234. W_D high until MemReady, then Done; W_D low the next cycle.
- Reset and NOP:
  - Drop Resetn during st T3 -> W_D=0 and Done=0 immediately; all registers 0, Z=1.
  - The next instruction after Resetn release executes normally.
  - NOP opcode 0xF -> Done at T1, no register change.
- Wide config, W=32, NREG=16:
  - shl with R0=0x00000003, R1=4 -> 0x00000030.
  - and 0xFFFF0000 & 0x0F0F0F0F -> 0x0F0F0000.
